// File: rtl/multi_edge_det.sv
// Multi-channel debounced edge detector with registered one-cycle ticks.
// Define MULTI_EDGE_DET_REPEAT_EN to add per-channel auto-repeat ticks while a channel stays high.
module multi_edge_det #(
  parameter int unsigned N             = 5,
  parameter int unsigned DB_CYCLES     = 16,
  parameter int unsigned EDGE_MODE     = 0,
  parameter int unsigned REPEAT_DELAY  = 1000,
  parameter int unsigned REPEAT_PERIOD = 250,
  localparam int unsigned IdxW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    level,
  output logic [N-1:0]    stable,
  output logic [N-1:0]    tick,
  output logic            tick_any,
  output logic [IdxW-1:0] tick_idx
);

  localparam int unsigned CntW = $clog2(DB_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);
  // Mode 3 falls back to rising-edge behaviour.
  localparam bit TickRise = (EDGE_MODE != 1);
  localparam bit TickFall = (EDGE_MODE == 1) || (EDGE_MODE == 2);

  if (N < 1 || N > 32 || DB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
  begin : g_bad_param
    $error("multi_edge_det: parameter out of range");
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic            s1_q, s2_q;
    logic            stable_q, stable_d;
    logic            tick_q, tick_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            accept;
    logic            rpt_fire;

    assign accept = (s2_q != stable_q) && (cnt_q == CntMax);

`ifdef MULTI_EDGE_DET_REPEAT_EN
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned RptW = $clog2(RptMax + 1);
    localparam logic [RptW-1:0] RptLoadDelay  = RptW'(REPEAT_DELAY - 1);
    localparam logic [RptW-1:0] RptLoadPeriod = RptW'(REPEAT_PERIOD - 1);

    logic [RptW-1:0] rpt_q, rpt_d;

    // Countdown to the next repeat tick; loaded on the press edge, cleared on release.
    always_comb begin
      rpt_d    = rpt_q;
      rpt_fire = 1'b0;
      if (accept) begin
        rpt_d = s2_q ? RptLoadDelay : '0;
      end else if (stable_q) begin
        if (rpt_q == '0) begin
          rpt_fire = 1'b1;
          rpt_d    = RptLoadPeriod;
        end else begin
          rpt_d = rpt_q - RptW'(1);
        end
      end else begin
        rpt_d = '0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rpt_q <= '0;
      end else begin
        rpt_q <= rpt_d;
      end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      tick_d   = rpt_fire;
      if (s2_q == stable_q) begin
        cnt_d = '0;
      end else if (accept) begin
        cnt_d    = '0;
        stable_d = s2_q;
        if (s2_q ? TickRise : TickFall) begin
          tick_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_q     <= 1'b0;
        s2_q     <= 1'b0;
        stable_q <= 1'b0;
        tick_q   <= 1'b0;
        cnt_q    <= '0;
      end else begin
        s1_q     <= level[i];
        s2_q     <= s1_q;
        stable_q <= stable_d;
        tick_q   <= tick_d;
        cnt_q    <= cnt_d;
      end
    end

    assign stable[i] = stable_q;
    assign tick[i]   = tick_q;
  end

  assign tick_any = |tick;

  // Descending scan so the lowest set index wins.
  always_comb begin
    tick_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (tick[i]) begin
        tick_idx = IdxW'(i);
      end
    end
  end

endmodule
